// File: rtl/seg7_capture_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared definitions for the 7-segment capture decoder:
//               active-low digit patterns, FSM state encoding and the
//               pattern-to-nibble decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Active-low segment patterns, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h18;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    // Capture FSM encoding
    typedef enum logic [1:0] {
        CAP_LO = 2'd0,
        CAP_HI = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Returns {illegal, nibble}; unknown patterns decode to nibble 0
    function automatic logic [4:0] seg_to_nibble(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            SEG_0:   r = 5'h00;
            SEG_1:   r = 5'h01;
            SEG_2:   r = 5'h02;
            SEG_3:   r = 5'h03;
            SEG_4:   r = 5'h04;
            SEG_5:   r = 5'h05;
            SEG_6:   r = 5'h06;
            SEG_7:   r = 5'h07;
            SEG_8:   r = 5'h08;
            SEG_9:   r = 5'h09;
            SEG_A:   r = 5'h0A;
            SEG_B:   r = 5'h0B;
            SEG_C:   r = 5'h0C;
            SEG_D:   r = 5'h0D;
            SEG_E:   r = 5'h0E;
            SEG_F:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_capture_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_capture_decoder_if
// Description : Segment-bus input side and valid/ready output side of the
//               capture decoder, bundled for port connection.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg7_capture_decoder_if;

    logic [6:0] seg_in;
    logic       seg_valid;
    logic       digit_sel;
    logic       out_ready;
    logic [7:0] out_value;
    logic       out_valid;
    logic       out_err;
    logic       busy;

    // Producer of the segment bus and consumer of the decoded value
    modport master (
        output seg_in,
        output seg_valid,
        output digit_sel,
        output out_ready,
        input  out_value,
        input  out_valid,
        input  out_err,
        input  busy
    );

    // The decoder itself
    modport slave (
        input  seg_in,
        input  seg_valid,
        input  digit_sel,
        input  out_ready,
        output out_value,
        output out_valid,
        output out_err,
        output busy
    );

endinterface
`default_nettype wire

// File: rtl/seg7_capture_decoder_stability_filter.sv
`default_nettype none
// ============================================================================
// Module      : seg7_stability_filter
// Description : Counts consecutive identical qualifying samples and pulses
//               accept when STABLE_CYCLES of them have been seen in a row.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_stability_filter #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       qualify,
    input  logic [6:0] seg_in,
    output logic       accept,
    output logic       count_nz
);

    localparam logic [CNT_W-1:0] C_STABLE = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    logic [6:0]       prev_q, prev_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] w_count_next;

    // Run-length update; the accepting edge returns the count to zero
    always_comb begin
        prev_d       = prev_q;
        count_d      = count_q;
        w_count_next = '0;
        accept       = 1'b0;
        if (qualify) begin
            if ((seg_in == prev_q) && (count_q != '0)) begin
                w_count_next = count_q + C_ONE;
            end else begin
                prev_d       = seg_in;
                w_count_next = C_ONE;
            end
            if (w_count_next == C_STABLE) begin
                accept  = 1'b1;
                count_d = '0;
            end else begin
                count_d = w_count_next;
            end
        end else begin
            count_d = '0;
        end
    end

    // Filter state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q  <= '0;
            count_q <= '0;
        end else begin
            prev_q  <= prev_d;
            count_q <= count_d;
        end
    end

    assign count_nz = (count_q != '0);

endmodule
`default_nettype wire

// File: rtl/seg7_capture_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_capture_decoder
// Description : Samples a two-digit multiplexed active-low 7-segment bus,
//               debounces each digit, decodes it and presents the assembled
//               byte on a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_capture_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    seg7_capture_decoder_if.slave bus
);

    state_t     state_q, state_d;
    logic [3:0] lo_q, lo_d;
    logic       err_q, err_d;
    logic [7:0] out_value_q, out_value_d;
    logic       out_valid_q, out_valid_d;
    logic       out_err_q, out_err_d;

    logic       w_qualify;
    logic       w_accept;
    logic       w_count_nz;
    logic [4:0] w_dec;

    // A sample counts only while the bus shows the digit this state expects
    assign w_qualify = bus.seg_valid &&
                       (((state_q == CAP_LO) && !bus.digit_sel) ||
                        ((state_q == CAP_HI) &&  bus.digit_sel));

    // On an accepting edge the current sample is the stable pattern
    assign w_dec = seg_to_nibble(bus.seg_in);

    seg7_stability_filter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_filter (
        .clock    (clock),
        .reset    (reset),
        .qualify  (w_qualify),
        .seg_in   (bus.seg_in),
        .accept   (w_accept),
        .count_nz (w_count_nz)
    );

    // Frame sequencing: low digit, high digit, then hold until consumed
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        err_d       = err_q;
        out_value_d = out_value_q;
        out_valid_d = out_valid_q;
        out_err_d   = out_err_q;
        case (state_q)
            CAP_LO: begin
                if (w_accept) begin
                    lo_d    = w_dec[3:0];
                    err_d   = err_q | w_dec[4];
                    state_d = CAP_HI;
                end
            end
            CAP_HI: begin
                if (w_accept) begin
                    out_value_d = {w_dec[3:0], lo_q};
                    out_err_d   = err_q | w_dec[4];
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    err_d       = 1'b0;
                    state_d     = CAP_LO;
                end
            end
            default: begin
                state_d = CAP_LO;
            end
        endcase
    end

    // FSM and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= CAP_LO;
            lo_q        <= '0;
            err_q       <= 1'b0;
            out_value_q <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            err_q       <= err_d;
            out_value_q <= out_value_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.out_value = out_value_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_err   = out_err_q;
    assign bus.busy      = (state_q != CAP_LO) || w_count_nz;

endmodule
`default_nettype wire

// File: tb/tb_seg7_capture_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_capture_decoder
// Description : Directed and random stimulus for seg7_capture_decoder,
//               checked every cycle against a behavioural frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_capture_decoder;

    localparam int STABLE = 4;
    localparam logic [6:0] LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    seg7_capture_decoder_if bus_if ();

    seg7_capture_decoder #(
        .STABLE_CYCLES (STABLE),
        .CNT_W         (8)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // Reference model state: phase 0 = low digit, 1 = high digit, 2 = holding
    int         m_phase = 0;
    int         m_run   = 0;
    logic [6:0] m_pat   = '0;
    logic [3:0] m_lo    = '0;
    logic       m_err   = 1'b0;
    logic [7:0] m_val   = '0;
    logic       m_vld   = 1'b0;
    logic       m_oerr  = 1'b0;

    function automatic int dec(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (LUT[i] == p) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented to it
    task automatic model_step();
        int  n;
        bit  q;
        if (rst) begin
            m_phase = 0; m_run = 0; m_pat = '0; m_lo = '0; m_err = 1'b0;
            m_val = '0; m_vld = 1'b0; m_oerr = 1'b0;
        end else if (m_phase == 2) begin
            if (m_vld && bus_if.out_ready) begin
                m_vld = 1'b0; m_err = 1'b0; m_run = 0; m_phase = 0;
            end
        end else begin
            q = bus_if.seg_valid && (bus_if.digit_sel == (m_phase == 1));
            if (!q) begin
                m_run = 0;
            end else begin
                if (bus_if.seg_in == m_pat && m_run != 0) begin
                    m_run++;
                end else begin
                    m_pat = bus_if.seg_in;
                    m_run = 1;
                end
                if (m_run == STABLE) begin
                    m_run = 0;
                    n = dec(bus_if.seg_in);
                    if (m_phase == 0) begin
                        m_lo    = (n < 0) ? 4'h0 : 4'(n);
                        m_err   = m_err | (n < 0);
                        m_phase = 1;
                    end else begin
                        m_val   = {((n < 0) ? 4'h0 : 4'(n)), m_lo};
                        m_oerr  = m_err | (n < 0);
                        m_vld   = 1'b1;
                        m_phase = 2;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("out_valid", 32'(bus_if.out_valid), 32'(m_vld));
        chk("out_value", 32'(bus_if.out_value), 32'(m_val));
        chk("out_err",   32'(bus_if.out_err),   32'(m_oerr));
        chk("busy",      32'(bus_if.busy),      32'(m_phase != 0 || m_run != 0));
    endtask

    task automatic drv(input logic [6:0] s, input logic v, input logic d, input logic r);
        bus_if.seg_in    = s;
        bus_if.seg_valid = v;
        bus_if.digit_sel = d;
        bus_if.out_ready = r;
        tick();
    endtask

    task automatic send(input logic [6:0] s, input logic d, input int n, input logic r);
        for (int i = 0; i < n; i++) drv(s, 1'b1, d, r);
    endtask

    initial begin
        logic [6:0] p;
        logic       d;
        int         len;

        bus_if.seg_in = '0; bus_if.seg_valid = 1'b0;
        bus_if.digit_sel = 1'b0; bus_if.out_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        drv(7'h00, 1'b0, 1'b0, 1'b0);
        drv(7'h00, 1'b0, 1'b0, 1'b0);
        chk("rst_valid", 32'(bus_if.out_valid), 32'h0);
        chk("rst_value", 32'(bus_if.out_value), 32'h0);
        chk("rst_busy",  32'(bus_if.busy),      32'h0);
        rst = 1'b0;

        // Normal frame: valid rises on the 8th sample edge for one cycle
        send(7'h12, 1'b0, 4, 1'b1);
        send(7'h30, 1'b1, 3, 1'b1);
        chk("norm_early", 32'(bus_if.out_valid), 32'h0);
        send(7'h30, 1'b1, 1, 1'b1);
        chk("norm_valid", 32'(bus_if.out_valid), 32'h1);
        chk("norm_value", 32'(bus_if.out_value), 32'h35);
        chk("norm_err",   32'(bus_if.out_err),   32'h0);
        drv(7'h30, 1'b1, 1'b1, 1'b1);
        chk("norm_1cyc",  32'(bus_if.out_valid), 32'h0);

        // Glitch rejection in the low digit
        send(7'h40, 1'b0, 2, 1'b1);
        send(7'h79, 1'b0, 1, 1'b1);
        send(7'h40, 1'b0, 4, 1'b1);
        send(7'h0E, 1'b1, 3, 1'b1);
        chk("glitch_early", 32'(bus_if.out_valid), 32'h0);
        send(7'h0E, 1'b1, 1, 1'b1);
        chk("glitch_value", 32'(bus_if.out_value), 32'hF0);
        chk("glitch_valid", 32'(bus_if.out_valid), 32'h1);
        drv(7'h00, 1'b0, 1'b0, 1'b1);

        // Illegal low digit, then a clean frame clears the error
        send(7'h7F, 1'b0, 4, 1'b1);
        send(7'h08, 1'b1, 4, 1'b1);
        chk("ill_value", 32'(bus_if.out_value), 32'hA0);
        chk("ill_err",   32'(bus_if.out_err),   32'h1);
        drv(7'h00, 1'b0, 1'b0, 1'b1);
        send(7'h06, 1'b0, 4, 1'b1);
        send(7'h03, 1'b1, 4, 1'b1);
        chk("clr_value", 32'(bus_if.out_value), 32'hBE);
        chk("clr_err",   32'(bus_if.out_err),   32'h0);
        drv(7'h00, 1'b0, 1'b0, 1'b1);

        // Backpressure: output held while the bus wiggles
        send(7'h78, 1'b0, 4, 1'b0);
        send(7'h18, 1'b1, 4, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drv(7'($urandom), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0);
            chk("bp_valid", 32'(bus_if.out_valid), 32'h1);
            chk("bp_value", 32'(bus_if.out_value), 32'h97);
            chk("bp_err",   32'(bus_if.out_err),   32'h0);
        end
        drv(7'h18, 1'b1, 1'b1, 1'b1);
        chk("bp_xfer", 32'(bus_if.out_valid), 32'h0);
        drv(7'h18, 1'b0, 1'b1, 1'b1);
        chk("bp_after", 32'(bus_if.out_valid), 32'h0);

        // digit_sel interference restarts the low-digit filter
        send(7'h19, 1'b0, 3, 1'b1);
        send(7'h19, 1'b1, 1, 1'b1);
        send(7'h19, 1'b0, 4, 1'b1);
        send(7'h02, 1'b1, 4, 1'b1);
        chk("dsel_value", 32'(bus_if.out_value), 32'h64);
        chk("dsel_valid", 32'(bus_if.out_valid), 32'h1);
        drv(7'h00, 1'b0, 1'b0, 1'b1);

        // Reset mid-frame discards the captured low digit
        send(7'h24, 1'b0, 4, 1'b1);
        rst = 1'b1;
        drv(7'h24, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        chk("rmid_busy",  32'(bus_if.busy),      32'h0);
        chk("rmid_valid", 32'(bus_if.out_valid), 32'h0);
        send(7'h40, 1'b0, 4, 1'b1);
        send(7'h79, 1'b1, 4, 1'b1);
        chk("rmid_value", 32'(bus_if.out_value), 32'h10);
        drv(7'h00, 1'b0, 1'b0, 1'b1);

        // Random bursts against the model
        for (int b = 0; b < 200; b++) begin
            if ($urandom_range(3, 0) != 0) p = LUT[$urandom_range(15, 0)];
            else                           p = 7'($urandom);
            d   = 1'($urandom_range(1, 0));
            len = $urandom_range(6, 1);
            for (int k = 0; k < len; k++) begin
                rst = ($urandom_range(199, 0) == 0);
                drv(p, ($urandom_range(9, 0) != 0), d, 1'($urandom_range(1, 0)));
            end
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_capture_decoder.md
Name: seg7_capture_decoder

Overview:
- Inverse of the team's hex-to-7-segment encoder. Samples an active-low 7-segment bus that is time-multiplexed between two digits: low nibble first, then high nibble.
- Filters each pattern for stability, decodes it back to a 4-bit nibble and assembles an 8-bit value.
- Presents the value on a valid/ready handshake.
- Used by the self-check path to read back the accumulator value shown on the HEX5:HEX4 displays.

Parameters:
- STABLE_CYCLES, 4, consecutive identical qualifying samples needed to accept a digit. Legal range 1..255.
- CNT_W, 8, width of the stability counter. Must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- seg_in  in  7  segment pattern, active-low (0 = lit); bit0=a, bit1=b … bit6=g.
- seg_valid  in  1  seg_in is meaningful this cycle.
- digit_sel  in  1  digit currently driven: 0 = low nibble, 1 = high nibble.
- out_ready  in  1  consumer accepts out_value.
- out_value  out  8  {high nibble, low nibble}.
- out_valid  out  1  out_value and out_err are held valid.
- out_err  out  1  at least one digit of this frame was an illegal pattern.
- busy  out  1  a frame is in progress (state != CAP_LO, or stability count != 0).

Behaviour:
- Reset (synchronous, active-high, wins over everything, including mid-frame and during HOLD):
  - state = CAP_LO; count = 0; prev = 0; lo = 0; err = 0.
  - out_value = 0, out_valid = 0, out_err = 0, busy = 0 from the next edge.
  - A partially captured frame is discarded.
- States: CAP_LO -> CAP_HI -> HOLD -> CAP_LO.
- Qualifying sample: seg_valid=1 and digit_sel matches the state (0 in CAP_LO, 1 in CAP_HI).
- Stability filter, per edge in CAP_LO and CAP_HI:
  - Non-qualifying sample: count = 0.
  - Qualifying sample with seg_in == prev and count != 0: count = count + 1.
  - Any other qualifying sample: prev = seg_in, count = 1.
  - A digit is accepted on the edge where the updated count would equal STABLE_CYCLES. On that edge count returns to 0.
  - With STABLE_CYCLES=1, the first qualifying sample is accepted.
- Decode table, active-low hex → nibble:
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7
  - 00→8, 18→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F
  - Any other pattern is illegal: nibble = 0 and err is set. err is sticky for the frame.
- Acceptance in CAP_LO: latch lo; go to CAP_HI.
- Acceptance in CAP_HI, on the same edge:
  - out_value = {hi, lo}; out_err = err | illegal(hi); out_valid = 1; go to HOLD.
- Latency: out_valid rises on the edge that samples the STABLE_CYCLES-th qualifying high-digit sample. Minimum frame is 2×STABLE_CYCLES cycles.
- HOLD:
  - seg_* inputs are ignored.
  - out_value, out_err and out_valid are held until out_valid & out_ready on an edge.
  - That transfer edge: out_valid = 0, err = 0, count = 0, state = CAP_LO. No sampling happens on the transfer edge.
  - out_ready while out_valid=0 has no effect.
- Digit switch mid-count (digit_sel toggles before acceptance): count clears; the filter restarts when a matching sample returns.
- A pattern change mid-count restarts the count at 1 with the new pattern.
- out_value keeps its last value after the transfer; only out_valid qualifies it.

Decomposition:
- Package seg7_pkg holds:
  - the 16 active-low pattern constants SEG_0..SEG_F;
  - the state encoding: CAP_LO = 2'd0, CAP_HI = 2'd1, HOLD = 2'd2;
  - a function seg_to_nibble returning {illegal, nibble[3:0]}.
- One sub-module, seg7_stability_filter: prev and count registers, qualify input, accept pulse output. The FSM and the output registers stay in the top module.

Test Plan:
- Reset mid-frame: accept low digit 0x24, assert reset 1 cycle, then send a full frame → state CAP_LO, busy=0, no stale low nibble in the following frame.
- Normal frame, STABLE_CYCLES=4, out_ready=1: low 0x12 ×4 cycles, then high 0x30 ×4 → out_valid=1 for exactly 1 cycle, out_value=0x35, out_err=0, out_valid rising on the 8th sample edge.
- Glitch rejection: low 0x40,0x40,0x79,0x40,0x40,0x40,0x40, then high 0x0E ×4 → out_value=0xF0; accepted only after the 4 consecutive 0x40.
- Illegal pattern: low 0x7F ×4, high 0x08 ×4 → out_value=0xA0, out_err=1. Next frame 0x06/0x03 → out_value=0xBE, out_err=0 (err cleared).
- Backpressure: complete a frame with out_ready=0 for 10 cycles while seg_in toggles arbitrarily → out_valid, out_value and out_err stable. Raise out_ready → one transfer, then out_valid=0.
- digit_sel interference: in CAP_LO, 3 qualifying samples of 0x19, 1 cycle with digit_sel=1, then 4 more of 0x19 → the low digit is accepted only after the last 4. High 0x02 ×4 → out_value=0x64.
